// File: rtl/qspi_pkg.sv
// Shared types and sizing for the QSPI receive deserialiser.
package qspi_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned QSPI_MAX_BYTES = 4;
  localparam int unsigned LEN_W          = 3;
  localparam int unsigned CNT_W          = 6;
  localparam int unsigned IO_W           = 4;

  typedef enum logic [1:0] {
    QSPI_SINGLE = 2'b00,
    QSPI_DUAL   = 2'b01,
    QSPI_QUAD   = 2'b10
  } qspi_mode_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_SHIFT = 2'b01,
    RX_HOLD  = 2'b10
  } rx_state_e;

endpackage

// File: rtl/qspi_rx_deser_if.sv
// Control, IO sample and read-data handshake bundle of the QSPI receive path.
interface qspi_rx_deser_if;
  import qspi_pkg::*;

  logic              start;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  rx_len;
  logic              sample_en;
  logic [IO_W-1:0]   io_in;
  logic              abort;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, rx_len, sample_en, io_in, abort, rx_ready,
    input  rx_data, rx_valid, busy, done
  );

  modport slave (
    input  start, mode, rx_len, sample_en, io_in, abort, rx_ready,
    output rx_data, rx_valid, busy, done
  );

endinterface

// File: rtl/qspi_rx_deser.sv
// QSPI receive deserialiser: samples IO lines on SCK strobes in single/dual/quad
// mode, packs 1-4 bytes MSB-first and hands the word over a valid/ready handshake.
module qspi_rx_deser
  import qspi_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  qspi_rx_deser_if.slave  rx_if
);

  rx_state_e         state_q, state_d;
  qspi_mode_e        mode_q, mode_d;
  logic [LEN_W-1:0]  bytes_q, bytes_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  total_beats;
  logic [DATA_W-1:0] sr_shift;

  // Beat total and next shift value follow the configuration latched at start.
  always_comb begin
    total_beats = {bytes_q, 3'b000};
    sr_shift    = {sr_q[DATA_W-2:0], rx_if.io_in[1]};
    case (mode_q)
      QSPI_SINGLE: begin
        total_beats = {bytes_q, 3'b000};
        sr_shift    = {sr_q[DATA_W-2:0], rx_if.io_in[1]};
      end
      QSPI_DUAL: begin
        total_beats = {1'b0, bytes_q, 2'b00};
        sr_shift    = {sr_q[DATA_W-3:0], rx_if.io_in[1:0]};
      end
      default: begin
        total_beats = {2'b00, bytes_q, 1'b0};
        sr_shift    = {sr_q[DATA_W-5:0], rx_if.io_in[3:0]};
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bytes_d    = bytes_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    done_d     = 1'b0;

    if (rx_if.abort) begin
      state_d    = RX_IDLE;
      cnt_d      = '0;
      sr_d       = '0;
      rx_valid_d = 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (rx_if.start) begin
            case (rx_if.mode)
              2'b00:   mode_d = QSPI_SINGLE;
              2'b01:   mode_d = QSPI_DUAL;
              default: mode_d = QSPI_QUAD;
            endcase
            // Out-of-range lengths fall back to a full word.
            if ((rx_if.rx_len == '0) || (rx_if.rx_len > LEN_W'(QSPI_MAX_BYTES))) begin
              bytes_d = LEN_W'(QSPI_MAX_BYTES);
            end else begin
              bytes_d = rx_if.rx_len;
            end
            cnt_d   = '0;
            sr_d    = '0;
            state_d = RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (rx_if.sample_en) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == (total_beats - CNT_W'(1))) begin
              rx_data_d  = sr_shift;
              rx_valid_d = 1'b1;
              state_d    = RX_HOLD;
            end
          end
        end
        RX_HOLD: begin
          if (rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
            done_d     = 1'b1;
            cnt_d      = '0;
            state_d    = RX_IDLE;
          end
        end
        default: begin
          state_d    = RX_IDLE;
          cnt_d      = '0;
          rx_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      mode_q     <= QSPI_SINGLE;
      bytes_q    <= LEN_W'(QSPI_MAX_BYTES);
      cnt_q      <= '0;
      sr_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bytes_q    <= bytes_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign rx_if.busy     = busy_q;
  assign rx_if.done     = done_q;

endmodule

// File: tb/tb_qspi_rx_deser.sv
// Directed bench for qspi_rx_deser: expected words queued at start, checked at handshake.
module tb_qspi_rx_deser;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_q[$];

  qspi_rx_deser_if bus ();

  qspi_rx_deser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [2:0] len);
    bus.mode   = m;
    bus.rx_len = len;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  // Drive beats first..last of word w, MSB-first, with gap idle cycles between strobes.
  task automatic feed(input logic [1:0] m, input int bytes, input logic [31:0] w,
                      input int first, input int last, input int gap);
    int bpb;
    int nbits;
    logic [31:0] chunk;
    logic [3:0]  io;
    bpb   = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    nbits = bytes * 8;
    for (int i = first; i <= last; i++) begin
      chunk = (w >> (nbits - (i + 1) * bpb)) & ((32'd1 << bpb) - 32'd1);
      io    = 4'($urandom);
      case (bpb)
        1:       io[1]   = chunk[0];
        2:       io[1:0] = chunk[1:0];
        default: io      = chunk[3:0];
      endcase
      bus.io_in     = io;
      bus.sample_en = 1'b1;
      step();
      bus.sample_en = 1'b0;
      if (i < last) begin
        for (int g = 0; g < gap; g++) begin
          bus.io_in = 4'($urandom);
          step();
          chk("gap_busy", 32'(bus.busy), 32'd1);
          chk("gap_valid", 32'(bus.rx_valid), 32'd0);
        end
      end
    end
  endtask

  // Called right after the final strobe edge; holds ready low for delay cycles.
  task automatic receive(input string tag, input int delay);
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    chk({tag, "_data"}, bus.rx_data, e);
    chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
    if (delay > 0) begin
      bus.rx_ready = 1'b0;
      for (int d = 0; d < delay; d++) begin
        step();
        chk({tag, "_hold_valid"}, 32'(bus.rx_valid), 32'd1);
        chk({tag, "_hold_data"}, bus.rx_data, e);
        chk({tag, "_hold_done"}, 32'(bus.done), 32'd0);
      end
    end
    bus.rx_ready = 1'b1;
    step();
    chk({tag, "_acc_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({tag, "_acc_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_acc_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 2'b00;
    bus.rx_len    = 3'd0;
    bus.sample_en = 1'b0;
    bus.io_in     = 4'h0;
    bus.abort     = 1'b0;
    bus.rx_ready  = 1'b0;
    repeat (2) step();
    chk("rst_data", bus.rx_data, 32'h0);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    step();

    // Quad, 4 bytes, ready already high.
    bus.rx_ready = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    do_start(2'b10, 3'd4);
    chk("q4_busy", 32'(bus.busy), 32'd1);
    feed(2'b10, 4, 32'hDEADBEEF, 0, 7, 0);
    receive("quad4", 0);
    step();
    chk("quad4_done_pulse", 32'(bus.done), 32'd0);

    // Strobes while idle are ignored.
    bus.sample_en = 1'b1;
    step();
    bus.sample_en = 1'b0;
    chk("idle_strobe_busy", 32'(bus.busy), 32'd0);
    chk("idle_strobe_valid", 32'(bus.rx_valid), 32'd0);

    // Single, 1 byte, gaps between strobes; next start issued while done is high.
    exp_q.push_back(32'h000000A5);
    do_start(2'b00, 3'd1);
    feed(2'b00, 1, 32'h000000A5, 0, 7, 2);
    receive("single1", 0);
    exp_q.push_back(32'h0000C972);
    bus.rx_ready = 1'b0;
    do_start(2'b01, 3'd2);
    chk("start_on_done_busy", 32'(bus.busy), 32'd1);

    // Dual, 2 bytes, consumer stalls 5 cycles.
    feed(2'b01, 2, 32'h0000C972, 0, 7, 0);
    receive("dual2", 5);

    // Start during SHIFT with a different mode/length must be ignored.
    exp_q.push_back(32'h00003C5A);
    do_start(2'b01, 3'd2);
    feed(2'b01, 2, 32'h00003C5A, 0, 3, 1);
    do_start(2'b10, 3'd1);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    chk("restart_valid", 32'(bus.rx_valid), 32'd0);
    feed(2'b01, 2, 32'h00003C5A, 4, 7, 0);
    receive("restart", 0);

    // Abort after 3 quad strobes: idle next cycle, old data retained, no done.
    do_start(2'b10, 3'd4);
    feed(2'b10, 4, 32'h12345678, 0, 2, 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_valid", 32'(bus.rx_valid), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_data_kept", bus.rx_data, 32'h00003C5A);
    repeat (3) begin
      bus.sample_en = 1'b1;
      step();
      chk("post_abort_valid", 32'(bus.rx_valid), 32'd0);
      chk("post_abort_done", 32'(bus.done), 32'd0);
    end
    bus.sample_en = 1'b0;

    // Abort and start together: abort wins.
    bus.abort = 1'b1;
    do_start(2'b10, 3'd1);
    bus.abort = 1'b0;
    chk("abort_start_busy", 32'(bus.busy), 32'd0);
    step();
    chk("abort_start_busy2", 32'(bus.busy), 32'd0);

    // New transfer after abort completes normally (counter restarted).
    exp_q.push_back(32'h00009A);
    do_start(2'b11, 3'd1);
    feed(2'b10, 1, 32'h0000009A, 0, 1, 0);
    receive("post_abort", 0);

    // Reset mid-transfer clears outputs asynchronously.
    do_start(2'b10, 3'd4);
    feed(2'b10, 4, 32'hCAFEF00D, 0, 4, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_data", bus.rx_data, 32'h0);
    chk("midrst_valid", 32'(bus.rx_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_busy", 32'(bus.busy), 32'd0);

    // rx_len = 0 means a full 4-byte word.
    exp_q.push_back(32'h0F1E2D3C);
    do_start(2'b10, 3'd0);
    feed(2'b10, 4, 32'h0F1E2D3C, 0, 6, 0);
    chk("len0_not_early", 32'(bus.rx_valid), 32'd0);
    feed(2'b10, 4, 32'h0F1E2D3C, 7, 7, 0);
    receive("len0", 2);

    // rx_len = 6 also means a full word, in single mode.
    exp_q.push_back(32'h80000001);
    do_start(2'b00, 3'd6);
    feed(2'b00, 4, 32'h80000001, 0, 31, 0);
    receive("len6_single", 0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
